main_irq_ctrl: RTL and testbench



---
 rtl/main_irq_ctrl_if.sv | 25 ++
 rtl/main_irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_main_irq_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/main_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for main_irq_ctrl: 3-bit address, 16-bit data,
// chipselect/write_n write strobe, registered readdata.
interface main_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/main_irq_ctrl.sv
// Interrupt aggregator: syncs raw irq lines, latches edge sources, masks, and reports
// the lowest active source. Define MAIN_IRQ_SW_TRIG_EN to build the SWTRIG register.
module main_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [15:0] EDGE_SENSE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  main_irq_ctrl_if.slave     bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [4:0]         active_id
);

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_STATUS  = 3'd2,
    REG_ACTIVE  = 3'd3,
    REG_RAW     = 3'd4,
    REG_SWTRIG  = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_addr_e;

  localparam logic [15:0] LINE_MASK  = 16'((32'h1 << NUM_IRQ) - 32'h1);
  localparam logic [15:0] EDGE_MASK  = EDGE_SENSE & LINE_MASK;
  localparam logic [15:0] LEVEL_MASK = ~EDGE_SENSE & LINE_MASK;

  logic [15:0] raw_ext;
  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] prev;
  logic [15:0] edge_pend;
  logic [15:0] enable;
  logic [15:0] sw_bits;
  logic [15:0] pending;
  logic [15:0] active;
  logic [15:0] w1c;
  logic [15:0] rd_next;
  logic        any_active;
  logic [3:0]  low_idx;
  logic        wr;
  logic        wr_pending;
  logic        wr_enable;

  always_comb begin
    raw_ext              = '0;
    raw_ext[NUM_IRQ-1:0] = irq_in;
  end

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr && (bus.address == REG_PENDING);
  assign wr_enable  = wr && (bus.address == REG_ENABLE);
  assign w1c        = wr_pending ? bus.writedata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= raw_ext & LINE_MASK;
      s2   <= s1;
      prev <= s2;
    end
  end

  // A rising edge detected in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= ((edge_pend & ~w1c) | (s2 & ~prev)) & EDGE_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable <= '0;
    end else if (wr_enable) begin
      enable <= bus.writedata & LINE_MASK;
    end
  end

`ifdef MAIN_IRQ_SW_TRIG_EN
  logic        wr_swtrig;
  logic [15:0] swpend;

  assign wr_swtrig = wr && (bus.address == REG_SWTRIG);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      swpend <= '0;
    end else if (wr_swtrig) begin
      swpend <= swpend | (bus.writedata & LINE_MASK);
    end else begin
      swpend <= swpend & ~w1c;
    end
  end

  assign sw_bits = swpend;
`else
  assign sw_bits = '0;
`endif

  assign pending = edge_pend | (s2 & LEVEL_MASK) | sw_bits;
  assign active  = pending & enable;

  always_comb begin
    any_active = 1'b0;
    low_idx    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (active[i] && !any_active) begin
        any_active = 1'b1;
        low_idx    = 4'(i);
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      REG_PENDING: rd_next = pending;
      REG_ENABLE:  rd_next = enable;
      REG_STATUS:  rd_next = active;
      REG_ACTIVE:  rd_next = {any_active, 11'b0, low_idx};
      REG_RAW:     rd_next = s2;
      REG_SWTRIG:  rd_next = sw_bits;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
      active_id    <= '0;
    end else begin
      bus.readdata <= rd_next;
      irq          <= any_active;
      active_id    <= {any_active, low_idx};
    end
  end

endmodule

// File: tb/tb_main_irq_ctrl.sv
// Self-checking bench for main_irq_ctrl: line 2 edge-sensed, all other lines level.
module tb_main_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq;
  logic [4:0] active_id;

  main_irq_ctrl_if bus ();

  main_irq_ctrl #(
    .NUM_IRQ    (8),
    .EDGE_SENSE (16'h0004)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .irq_in    (irq_in),
    .irq       (irq),
    .active_id (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0]  lines;
    logic [15:0] en;
    logic [7:0]  en_rd;
    logic [7:0]  status;
    logic [4:0]  id;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
    sb_t s;
    sbq.push_back('{n, e});
    bus.address = a;
    tick();
    s = sbq.pop_front();
    check(s.name, bus.readdata, s.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h2A, 16'h0028, 8'h28, 8'h28, 5'b1_0011};
    vecs[1] = '{8'h2A, 16'h0020, 8'h20, 8'h20, 5'b1_0101};
    vecs[2] = '{8'h2A, 16'hFF00, 8'h00, 8'h00, 5'b0_0000};
    vecs[3] = '{8'hFB, 16'hFFFF, 8'hFF, 8'hFB, 5'b1_0000};
    vecs[4] = '{8'h80, 16'h00C0, 8'hC0, 8'h80, 5'b1_0111};
    vecs[5] = '{8'h00, 16'h00FF, 8'hFF, 8'h00, 5'b0_0000};
    vecs[6] = '{8'h42, 16'h0042, 8'h42, 8'h42, 5'b1_0001};

    // Reset held with all lines high and a write attempted
    reset_n        = 1'b0;
    irq_in         = 8'hFF;
    bus.address    = 3'd1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 16'hFFFF;
    repeat (3) tick();
    check("rst_readdata", bus.readdata, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_active_id", {11'b0, active_id}, 16'h0000);
    reset_n        = 1'b1;
    irq_in         = 8'h00;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(3'd1, 16'h0000, "rst_enable");
    rd(3'd4, 16'h0000, "rst_raw");

    // Steady-state vectors over level lines
    for (int i = 0; i < 7; i++) begin
      irq_in = vecs[i].lines;
      wr(3'd1, vecs[i].en);
      repeat (3) tick();
      rd(3'd1, {8'h00, vecs[i].en_rd}, $sformatf("vec%0d_enable", i));
      rd(3'd0, {8'h00, vecs[i].lines}, $sformatf("vec%0d_pending", i));
      rd(3'd2, {8'h00, vecs[i].status}, $sformatf("vec%0d_status", i));
      rd(3'd3, {vecs[i].id[4], 11'b0, vecs[i].id[3:0]}, $sformatf("vec%0d_active", i));
      rd(3'd4, {8'h00, vecs[i].lines}, $sformatf("vec%0d_raw", i));
      check($sformatf("vec%0d_irq", i), {15'b0, irq}, {15'b0, vecs[i].id[4]});
      check($sformatf("vec%0d_id", i), {11'b0, active_id}, {11'b0, vecs[i].id});
    end

    // Mask change moves active_id one edge after the write
    irq_in = 8'h2A;
    wr(3'd1, 16'h0028);
    repeat (3) tick();
    check("mask_id_before", {11'b0, active_id}, 16'h0013);
    wr(3'd1, 16'h0020);
    check("mask_id_write_edge", {11'b0, active_id}, 16'h0013);
    tick();
    check("mask_id_after", {11'b0, active_id}, 16'h0015);

    irq_in = 8'h00;
    repeat (3) tick();

    // Level line 0: irq two edges after the rising input, same on release
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    tick();
    check("lvl_irq_n1", {15'b0, irq}, 16'h0000);
    tick();
    check("lvl_irq_n2", {15'b0, irq}, 16'h0001);
    rd(3'd3, 16'h8000, "lvl_active");
    irq_in = 8'h00;
    tick();
    tick();
    check("lvl_fall_m1", {15'b0, irq}, 16'h0001);
    tick();
    check("lvl_fall_m2", {15'b0, irq}, 16'h0000);

    // Edge line 2: one-cycle pulse latched, irq three edges later, W1C clears
    wr(3'd1, 16'h0004);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    check("edge_irq_n1", {15'b0, irq}, 16'h0000);
    tick();
    check("edge_irq_n2", {15'b0, irq}, 16'h0000);
    tick();
    check("edge_irq_n3", {15'b0, irq}, 16'h0001);
    rd(3'd0, 16'h0004, "edge_pending_held");
    check("edge_irq_held", {15'b0, irq}, 16'h0001);
    wr(3'd0, 16'h0004);
    check("edge_w1c_edge", {15'b0, irq}, 16'h0001);
    tick();
    check("edge_w1c_next", {15'b0, irq}, 16'h0000);
    rd(3'd0, 16'h0000, "edge_pending_cleared");

    // W1C lands on the edge where the synchronised rise is detected
    irq_in = 8'h04;
    tick();
    tick();
    wr(3'd0, 16'h0004);
    tick();
    check("coll_irq", {15'b0, irq}, 16'h0001);
    rd(3'd0, 16'h0004, "coll_pending");
    check("coll_irq_hold", {15'b0, irq}, 16'h0001);
    irq_in = 8'h00;
    wr(3'd0, 16'h0004);
    tick();
    tick();
    check("coll_cleanup_irq", {15'b0, irq}, 16'h0000);

    // Software trigger register
    wr(3'd5, 16'h0080);
    wr(3'd1, 16'h0080);
    tick();
`ifdef MAIN_IRQ_SW_TRIG_EN
    check("sw_irq", {15'b0, irq}, 16'h0001);
    check("sw_id", {11'b0, active_id}, 16'h0017);
    rd(3'd5, 16'h0080, "sw_read");
    rd(3'd0, 16'h0080, "sw_pending");
    wr(3'd0, 16'h0080);
    tick();
    check("sw_irq_cleared", {15'b0, irq}, 16'h0000);
    rd(3'd5, 16'h0000, "sw_read_cleared");
`else
    check("sw_irq_absent", {15'b0, irq}, 16'h0000);
    check("sw_id_absent", {11'b0, active_id}, 16'h0000);
    rd(3'd5, 16'h0000, "sw_read_absent");
`endif

    wr(3'd6, 16'hFFFF);
    wr(3'd7, 16'hFFFF);
    rd(3'd6, 16'h0000, "rsvd6");
    rd(3'd7, 16'h0000, "rsvd7");
    rd(3'd1, 16'h0080, "enable_after_rsvd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
